// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit sitting directly behind the ALU. The ALU result is used as
// the effective address and rs2 as store data. One access is run on a simple
// req/ack data bus; the core is stalled with busy_o until done_o pulses.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   when defined, an access that waits TIMEOUT_CYCLES cycles in REQ without an
//   ack is aborted and completes with timeout_o=1. When undefined, REQ waits
//   indefinitely, timeout_o is tied low and no counter exists.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   start_i            request an access (sampled only in IDLE)
//   we_i, funct3_i     store/load select and RISC-V size/sign code
//   addr_i, wdata_i    effective address and store data
//   busy_o, done_o     stall while an access runs, one-cycle completion pulse
//   rdata_o            aligned/extended load data, held until the next done_o
//   misaligned_o, illegal_o, timeout_o   fault flags, pulse with done_o
//   bus_req_o .. bus_wdata_o             bus request side
//   bus_ack_i, bus_rdata_i               bus response side
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;

`ifdef MEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 to_q, to_d;
`else
    // Parameters are kept for a uniform interface; they only matter with
    // the timeout feature compiled in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES[0], TIMEOUT_W[0]};
`endif

    // ------------------------------------------------------------------
    // Access decode helpers
    // ------------------------------------------------------------------
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we) return (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        else    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // f3[2] set selects zero extension (LBU/LHU).
    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3[1:0])
            2'b00:   return {{24{b[7] & ~f3[2]}}, b};
            2'b01:   return {{16{h[15] & ~f3[2]}}, h};
            default: return d;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        ill_d    = ill_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    we_d     = we_i;
                    funct3_d = funct3_i;
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    mis_d    = 1'b0;
                    ill_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    to_d     = 1'b0;
                    cnt_d    = '0;
`endif
                    // Faults complete without touching the bus; illegal
                    // is checked first so it masks misalignment.
                    if (is_illegal(we_i, funct3_i)) begin
                        ill_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else if (is_misaligned(funct3_i, addr_i[1:0])) begin
                        mis_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack_i) begin
                    if (!we_q) rdata_d = extract_load(funct3_q, addr_q[1:0], bus_rdata_i);
                    state_d = S_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                // Ack on the limit edge takes the branch above.
                else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    rdata_d = 32'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_RESP);
        rdata_o      = rdata_q;
        misaligned_o = (state_q == S_RESP) && mis_q;
        illegal_o    = (state_q == S_RESP) && ill_q;
`ifdef MEM_TIMEOUT_EN
        timeout_o    = (state_q == S_RESP) && to_q;
`else
        timeout_o    = 1'b0;
`endif
        // Bus side is driven only while requesting so it idles at zero.
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_o   = 32'd0;
        bus_be_o     = 4'b0000;
        bus_wdata_o  = 32'd0;
        if (state_q == S_REQ) begin
            bus_req_o   = 1'b1;
            bus_we_o    = we_q;
            bus_addr_o  = {addr_q[31:2], 2'b00};
            bus_be_o    = byte_en(funct3_q, addr_q[1:0]);
            bus_wdata_o = lane_wdata(funct3_q, wdata_q);
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 as store data, and runs one access on a simple req/ack data bus.
- Generates byte enables and lane-replicated write data; aligns and sign/zero-extends load data for the writeback mux.
- Holds busy_o high to stall the core until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles in REQ without ack before abort (used only with MEM_TIMEOUT_EN)
TIMEOUT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start_i  input  1  request a load/store; sampled only in IDLE
we_i  input  1  1 = store, 0 = load
funct3_i  input  3  RISC-V size/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
addr_i  input  32  effective address from ALU result
wdata_i  input  32  store data (rs2)
busy_o  output  1  high from the cycle after start acceptance until done_o
done_o  output  1  one-cycle completion pulse
rdata_o  output  32  aligned, extended load data; valid with done_o, held until next done_o
misaligned_o  output  1  pulses with done_o on an alignment fault
illegal_o  output  1  pulses with done_o on an unsupported funct3
timeout_o  output  1  pulses with done_o on a bus timeout
bus_req_o  output  1  bus request, held until ack
bus_we_o  output  1  bus write strobe
bus_addr_o  output  32  word address {addr[31:2],2'b00}
bus_be_o  output  4  byte enables
bus_wdata_o  output  32  lane-replicated write data
bus_ack_i  input  1  bus acknowledge; single-cycle pulse
bus_rdata_i  input  32  read data; valid when bus_ack_i=1

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; every output 0, including rdata_o and bus_be_o; timeout counter 0.
- Reset mid-access: the next edge returns to IDLE and drops bus_req_o; no done_o is produced. An ack arriving after reset is ignored.
- States: IDLE, REQ, RESP.
- IDLE, start_i=1:
  - Capture we, funct3, addr and wdata; these registered values drive all later outputs.
  - Illegal funct3 goes to RESP with illegal_o set, and no bus request is issued. Illegal codes: loads 011/110/111; stores any code other than 000/001/010.
  - Misaligned access goes to RESP with misaligned_o set, and no bus request is issued. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal takes priority over misaligned.
  - Otherwise go to REQ.
- REQ:
  - bus_req_o=1; bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o are stable for the whole state.
  - bus_ack_i=1 goes to RESP. Load data is extracted from bus_rdata_i on that same edge.
  - Ack may arrive in the first REQ cycle.
- RESP: done_o=1 for exactly one cycle, then IDLE.
  - On a fault, rdata_o is 0.
  - A load updates rdata_o; a store leaves rdata_o unchanged.
- busy_o=1 in REQ and RESP.
- start_i is ignored outside IDLE. bus_ack_i is ignored outside REQ.
- Latency: start accepted at edge N; bus_req_o high after N; done_o high in the cycle after the ack edge. Minimum is 2 cycles start-to-done with a bus access, 1 cycle on a fault.
- Byte enables and write data:
  - Byte: be=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - Half: be=addr[1]?4'b1100:4'b0011; wdata={2{wdata[15:0]}}.
  - Word: be=4'b1111; wdata unchanged.
  - Loads use the same byte enables.
- Load extraction: select the lane by addr[1:0] for a byte or addr[1] for a half. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Back-to-back: start_i high in the cycle done_o returns to IDLE is accepted on the next edge.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - The counter clears on entering REQ and increments each REQ cycle without ack.
  - If it reaches TIMEOUT_CYCLES, drop bus_req_o and go to RESP with timeout_o=1 and rdata_o=0.
  - Ack on the same edge as the limit wins; the access completes normally.
- Undefined: REQ waits indefinitely; timeout_o is tied to 0; no counter is synthesised.

Test Plan:
- LW addr 0x100, ack 3 cycles after req, bus_rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, rdata_o 0xDEADBEEF with done_o the cycle after ack; busy_o high throughout.
- LB addr 0x103, bus_rdata 0x80123456 -> be 1000, rdata_o 0xFFFFFF80; repeat with LBU -> 0x00000080; LHU addr 0x102 -> 0x00008012.
- SH addr 0x202, wdata 0x1234ABCD -> bus_addr 0x200, be 1100, bus_we 1, bus_wdata 0xABCDABCD; rdata_o unchanged.
- LW addr 0x102 -> no bus_req_o ever; misaligned_o=1 and done_o=1 one cycle after start; funct3 011 load -> illegal_o=1 likewise.
- reset=0 for one cycle while in REQ (no ack yet) -> bus_req_o 0 next cycle, no done_o, a later ack is ignored, outputs 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req_o high 4 cycles, then done_o with timeout_o=1 and rdata_o=0.
